// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: issue stage in front of a 32-bit combinational ALU.
//
// Commands are buffered in a DEPTH-entry FIFO. The head entry drives the ALU
// inputs combinationally. The ALU result and flags are captured into one
// registered response slot with a valid/ready handshake. SGT (5) and SLT (7)
// are resolved here, so the response always carries a defined 0/1 result.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_*               command request (valid/ready, opcode, operands, shamt, tag)
//   alu_opcode/input1/input2/shiftValue   drive to the ALU (0 while the FIFO is empty)
//   alu_result/carryFlag/zeroFlag/signFlag   ALU outputs
//   rsp_*               registered response (valid/ready, result, flags, tag, err)
//   q_count             FIFO occupancy; the response slot is not counted
module alu_cmd_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // command side
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_opcode,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [4:0]               cmd_shamt,
    input  logic [TAG_W-1:0]         cmd_tag,
    // ALU side
    output logic [3:0]               alu_opcode,
    output logic [WIDTH-1:0]         alu_input1,
    output logic [WIDTH-1:0]         alu_input2,
    output logic [4:0]               alu_shiftValue,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carryFlag,
    input  logic                     alu_zeroFlag,
    input  logic                     alu_signFlag,
    // response side
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_carry,
    output logic                     rsp_zero,
    output logic                     rsp_sign,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [3:0] OpSgt       = 4'd5;
    localparam logic [3:0] OpSlt       = 4'd7;
    localparam logic [3:0] OpLastLegal = 4'd10;

    // FIFO storage. Not reset: contents are only visible while counted valid.
    logic [3:0]       op_mem_q  [DEPTH];
    logic [WIDTH-1:0] a_mem_q   [DEPTH];
    logic [WIDTH-1:0] b_mem_q   [DEPTH];
    logic [4:0]       sh_mem_q  [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_sign_q, rsp_sign_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

    logic             q_empty;
    logic             push;
    logic             slot_free;
    logic             issue;
    logic [3:0]       head_op;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [4:0]       head_sh;
    logic [TAG_W-1:0] head_tag;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_res;

    // Handshake decode; cmd_ready depends on registered occupancy only.
    assign q_empty   = (count_q == '0);
    assign cmd_ready = (count_q != CntW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign issue     = !q_empty && slot_free;

    assign head_op  = op_mem_q[rd_ptr_q];
    assign head_a   = a_mem_q[rd_ptr_q];
    assign head_b   = b_mem_q[rd_ptr_q];
    assign head_sh  = sh_mem_q[rd_ptr_q];
    assign head_tag = tag_mem_q[rd_ptr_q];

    assign cmp_gt  = ($signed(head_a) > $signed(head_b));
    assign cmp_lt  = ($signed(head_a) < $signed(head_b));
    assign cmp_res = (head_op == OpSgt) ? cmp_gt : cmp_lt;

    // ALU drive: quiet zeros while empty so stale storage never reaches the ALU.
    always_comb begin
        alu_opcode     = '0;
        alu_input1     = '0;
        alu_input2     = '0;
        alu_shiftValue = '0;
        if (!q_empty) begin
            alu_opcode     = head_op;
            alu_input1     = head_a;
            alu_input2     = head_b;
            alu_shiftValue = head_sh;
        end
    end

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, issue})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Response slot next state. Data registers only move on issue, which keeps
    // them stable while a response is stalled.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_sign_d   = rsp_sign_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        if (issue) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_carry_d  = alu_carryFlag;
            rsp_zero_d   = alu_zeroFlag;
            rsp_sign_d   = alu_signFlag;
            rsp_tag_d    = head_tag;
            rsp_err_d    = (head_op > OpLastLegal);
            // Signed compares are resolved locally; the ALU output is ignored.
            if ((head_op == OpSgt) || (head_op == OpSlt)) begin
                rsp_result_d = WIDTH'(cmp_res);
                rsp_zero_d   = !cmp_res;
                rsp_sign_d   = 1'b0;
                rsp_carry_d  = 1'b0;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q]  <= cmd_opcode;
            a_mem_q[wr_ptr_q]   <= cmd_a;
            b_mem_q[wr_ptr_q]   <= cmd_b;
            sh_mem_q[wr_ptr_q]  <= cmd_shamt;
            tag_mem_q[wr_ptr_q] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_sign_q   <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_sign_q   <= rsp_sign_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_sign   = rsp_sign_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign q_count    = count_q;

endmodule
